// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants and FSM state type for the TPU result reader
package tpu_pkg;

  localparam int ARRAY_SIZE     = 8;
  localparam int OUT_DATA_WIDTH = 16;
  localparam int DIAG_NUM       = 2 * ARRAY_SIZE - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/tpu_diag_unpack.sv
// rtl/tpu_diag_unpack.sv - maps one anti-diagonal SRAM word to per-slot buffer writes
module tpu_diag_unpack #(
  parameter int ARRAY_SIZE     = tpu_pkg::ARRAY_SIZE,
  parameter int OUT_DATA_WIDTH = tpu_pkg::OUT_DATA_WIDTH,
  localparam int ROW_W = ARRAY_SIZE * OUT_DATA_WIDTH,
  localparam int IDX_W = $clog2(ARRAY_SIZE),
  localparam int K_W   = $clog2(2 * ARRAY_SIZE - 1)
) (
  input  logic [K_W-1:0]                                k,
  input  logic [ROW_W-1:0]                              word,
  output logic [ARRAY_SIZE-1:0]                         wr_en,
  output logic [ARRAY_SIZE-1:0][IDX_W-1:0]              wr_row,
  output logic [ARRAY_SIZE-1:0][IDX_W-1:0]              wr_col,
  output logic [ARRAY_SIZE-1:0][OUT_DATA_WIDTH-1:0]     wr_data,
  output logic                                          pad_nz
);

  int kk;
  int hi;
  int lo;
  int ii;

  // Slot s carries row i = min(k,N-1)-s; slots past the diagonal length are padding.
  always_comb begin
    kk     = int'(k);
    hi     = (kk < ARRAY_SIZE) ? kk : ARRAY_SIZE - 1;
    lo     = (kk > ARRAY_SIZE - 1) ? kk - (ARRAY_SIZE - 1) : 0;
    ii     = 0;
    pad_nz = 1'b0;
    wr_en  = '0;
    wr_row = '0;
    wr_col = '0;
    wr_data = '0;
    for (int s = 0; s < ARRAY_SIZE; s++) begin
      ii         = hi - s;
      wr_data[s] = word[(ARRAY_SIZE - 1 - s) * OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
      wr_en[s]   = (s <= hi - lo);
      wr_row[s]  = IDX_W'(ii);
      wr_col[s]  = IDX_W'(kk - ii);
      if (!wr_en[s] && (wr_data[s] != '0)) begin
        pad_nz = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tpu_result_reader.sv
// rtl/tpu_result_reader.sv - reads a diagonal-packed result matrix from SRAM and streams it row by row
module tpu_result_reader #(
  parameter int ARRAY_SIZE     = tpu_pkg::ARRAY_SIZE,
  parameter int OUT_DATA_WIDTH = tpu_pkg::OUT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = 6,
  localparam int ROW_W = ARRAY_SIZE * OUT_DATA_WIDTH,
  localparam int IDX_W = $clog2(ARRAY_SIZE)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  input  logic [1:0]            bank_sel,
  input  logic [ROW_W-1:0]      sram_rdata_c0,
  input  logic [ROW_W-1:0]      sram_rdata_c1,
  input  logic [ROW_W-1:0]      sram_rdata_c2,
  output logic [ADDR_WIDTH-1:0] sram_raddr_c0,
  output logic [ADDR_WIDTH-1:0] sram_raddr_c1,
  output logic [ADDR_WIDTH-1:0] sram_raddr_c2,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [ROW_W-1:0]      row_data,
  output logic [IDX_W-1:0]      row_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  fmt_err
);

  import tpu_pkg::*;

  localparam int NDIAG = 2 * ARRAY_SIZE - 1;
  localparam int CNT_W = $clog2(NDIAG + 1);
  localparam int K_W   = $clog2(NDIAG);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              bank;
  logic                    start_ok;
  logic                    issue;
  logic                    capture;
  logic                    last_row;
  logic [ROW_W-1:0]        rdata;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic [OUT_DATA_WIDTH-1:0] buf_mem [ARRAY_SIZE * ARRAY_SIZE];

  logic [ARRAY_SIZE-1:0]                     wr_en;
  logic [ARRAY_SIZE-1:0][IDX_W-1:0]          wr_row;
  logic [ARRAY_SIZE-1:0][IDX_W-1:0]          wr_col;
  logic [ARRAY_SIZE-1:0][OUT_DATA_WIDTH-1:0] wr_data;
  logic                                      pad_nz;

  // cnt doubles as the issue address (0..NDIAG-1) and, one behind, the captured diagonal.
  assign start_ok  = start && (bank_sel != 2'd3);
  assign issue     = (state == READ) && (cnt < CNT_W'(NDIAG));
  assign capture   = (state == READ) && (cnt != '0);
  assign last_row  = (row_idx == IDX_W'(ARRAY_SIZE - 1));
  assign raddr     = issue ? ADDR_WIDTH'(cnt) : '0;
  assign busy      = (state != IDLE);
  assign row_valid = (state == OUT);

  assign sram_raddr_c0 = (bank == 2'd0) ? raddr : '0;
  assign sram_raddr_c1 = (bank == 2'd1) ? raddr : '0;
  assign sram_raddr_c2 = (bank == 2'd2) ? raddr : '0;

  // Read data from the bank latched at start.
  always_comb begin
    rdata = sram_rdata_c2;
    case (bank)
      2'd0:    rdata = sram_rdata_c0;
      2'd1:    rdata = sram_rdata_c1;
      default: rdata = sram_rdata_c2;
    endcase
  end

  tpu_diag_unpack #(
    .ARRAY_SIZE     (ARRAY_SIZE),
    .OUT_DATA_WIDTH (OUT_DATA_WIDTH)
  ) u_unpack (
    .k       (K_W'(cnt - CNT_W'(1))),
    .word    (rdata),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .pad_nz  (pad_nz)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: READ ends once the last diagonal is captured, OUT once row N-1 is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = READ;
      READ:    if (cnt == CNT_W'(NDIAG)) state_next = OUT;
      OUT:     if (row_ready && last_row) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters, latched bank and status flags.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt     <= '0;
      bank    <= 2'd0;
      row_idx <= '0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      fmt_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          row_idx <= '0;
          if (start) begin
            if (bank_sel == 2'd3) begin
              cfg_err <= 1'b1;
            end else begin
              bank    <= bank_sel;
              fmt_err <= 1'b0;
            end
          end
        end
        READ: begin
          cnt <= cnt + 1'b1;
          if (capture && pad_nz) fmt_err <= 1'b1;
        end
        OUT: begin
          if (row_ready) begin
            row_idx <= row_idx + 1'b1;
            if (last_row) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Matrix buffer: each captured diagonal scatters its valid slots into C[i][j].
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int e = 0; e < ARRAY_SIZE * ARRAY_SIZE; e++) buf_mem[e] <= '0;
    end else if (capture) begin
      for (int s = 0; s < ARRAY_SIZE; s++) begin
        if (wr_en[s]) buf_mem[{wr_row[s], wr_col[s]}] <= wr_data[s];
      end
    end
  end

  // Present the current row with column j in bits [16j+15:16j].
  always_comb begin
    row_data = '0;
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      row_data[j * OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = buf_mem[{row_idx, IDX_W'(j)}];
    end
  end

endmodule

// File: tb/tb_tpu_result_reader.sv
// tb/tb_tpu_result_reader.sv - self-checking bench for tpu_result_reader
module tb_tpu_result_reader;

  logic         clk = 1'b0;
  logic         srst;
  logic         start;
  logic [1:0]   bank_sel;
  logic [127:0] rdata_c0, rdata_c1, rdata_c2;
  logic [5:0]   raddr_c0, raddr_c1, raddr_c2;
  logic         row_valid;
  logic         row_ready;
  logic [127:0] row_data;
  logic [2:0]   row_idx;
  logic         busy, done, cfg_err, fmt_err;

  logic [127:0] mem_c0 [16];
  logic [127:0] mem_c1 [16];
  logic [127:0] mem_c2 [16];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int bank;
    int pat;
    int mode;
    bit pad;
    bit sio;
    bit exp_fmt;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  tpu_result_reader dut (
    .clk           (clk),
    .srst          (srst),
    .start         (start),
    .bank_sel      (bank_sel),
    .sram_rdata_c0 (rdata_c0),
    .sram_rdata_c1 (rdata_c1),
    .sram_rdata_c2 (rdata_c2),
    .sram_raddr_c0 (raddr_c0),
    .sram_raddr_c1 (raddr_c1),
    .sram_raddr_c2 (raddr_c2),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_data      (row_data),
    .row_idx       (row_idx),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .fmt_err       (fmt_err)
  );

  // SRAM models with one-cycle registered read.
  always @(posedge clk) begin
    rdata_c0 <= mem_c0[raddr_c0[3:0]];
    rdata_c1 <= mem_c1[raddr_c1[3:0]];
    rdata_c2 <= mem_c2[raddr_c2[3:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] elem(input int p, input int i, input int j);
    case (p)
      0:       return 16'(16 * i + j);
      1:       return (i == 2 && j == 5) ? 16'h8000 : 16'(40960 + 16 * i + j);
      2:       return 16'(65535 - 3 * (8 * i + j));
      default: return 16'h5A5A ^ 16'(i * 257 + j * 31);
    endcase
  endfunction

  function automatic logic [127:0] exp_row(input int p, input int i);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[16 * j +: 16] = elem(p, i, j);
    return r;
  endfunction

  // Pack matrix p into anti-diagonal words: C[i][j] goes to word i+j, slot min(i+j,7)-i.
  task automatic load(input int b, input int p, input bit pad);
    logic [127:0] w [16];
    int k, s;
    for (int a = 0; a < 16; a++) w[a] = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        k = i + j;
        s = ((k < 8) ? k : 7) - i;
        w[k][127 - 16 * s -: 16] = elem(p, i, j);
      end
    end
    if (pad) w[0][111:96] = 16'h0001;
    for (int a = 0; a < 16; a++) begin
      case (b)
        0:       mem_c0[a] = w[a];
        1:       mem_c1[a] = w[a];
        default: mem_c2[a] = w[a];
      endcase
    end
  endtask

  // One full readout, called and returning at a falling edge.
  task automatic run_readout(input int bank, input int pat, input int mode, input bit sio,
                             input bit exp_fmt, input bit chain, input int chain_bank);
    int lat, bad_addr, rows;
    bit held, rdy;
    logic [127:0] hold_data;
    logic [2:0] hold_idx;
    logic [17:0] exp_addr;
    start    = 1'b1;
    bank_sel = 2'(bank);
    @(negedge clk);
    start    = 1'b0;
    bank_sel = 2'((bank + 1) % 3);
    check("busy_after_start", 128'(busy), 128'(1));
    check("fmt_clr", 128'(fmt_err), 128'(0));
    lat = 0;
    bad_addr = 0;
    for (int n = 1; n <= 40; n++) begin
      if (row_valid) begin
        lat = n;
        break;
      end
      if (n <= 15) begin
        exp_addr = 18'(n - 1) << (6 * bank);
        if ({raddr_c2, raddr_c1, raddr_c0} !== exp_addr) bad_addr++;
      end
      @(negedge clk);
    end
    check("raddr_seq", 128'(bad_addr), 128'(0));
    check("latency", 128'(lat), 128'(17));
    rows = 0;
    held = 1'b0;
    hold_data = '0;
    hold_idx = '0;
    for (int c = 0; c < 60 && rows < 8; c++) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : (c >= 3);
      row_ready = rdy;
      if (sio) begin
        start = (c == 2);
        bank_sel = 2'((bank + 2) % 3);
      end
      check("row_valid", 128'(row_valid), 128'(1));
      if (held) begin
        check("hold_data", row_data, hold_data);
        check("hold_idx", 128'(row_idx), 128'(hold_idx));
      end
      if (row_valid && rdy) begin
        check("row_idx", 128'(row_idx), 128'(rows));
        check("row_data", row_data, exp_row(pat, rows));
        if (pat == 0 && rows == 3)
          check("row3_const", row_data, 128'h0037_0036_0035_0034_0033_0032_0031_0030);
        if (pat == 1 && rows == 2)
          check("neg_max", 128'(row_data[95:80]), 128'(16'h8000));
        rows++;
        held = 1'b0;
      end else begin
        held = row_valid;
        hold_data = row_data;
        hold_idx = row_idx;
      end
      @(negedge clk);
    end
    start = 1'b0;
    row_ready = 1'b0;
    check("row_count", 128'(rows), 128'(8));
    check("done_pulse", 128'(done), 128'(1));
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_valid", 128'(row_valid), 128'(0));
    check("fmt_err", 128'(fmt_err), 128'(exp_fmt));
    if (chain) begin
      start = 1'b1;
      bank_sel = 2'(chain_bank);
      @(negedge clk);
      start = 1'b0;
      check("chain_busy", 128'(busy), 128'(1));
    end else begin
      @(negedge clk);
      check("done_clear", 128'(done), 128'(0));
      check("stay_idle", 128'(busy), 128'(0));
    end
  endtask

  initial begin
    int done_cnt;
    srst = 1'b1;
    start = 1'b0;
    bank_sel = 2'd0;
    row_ready = 1'b0;
    for (int b = 0; b < 3; b++) load(b, 3, 1'b0);
    tbl[0] = '{bank: 0, pat: 0, mode: 0, pad: 1'b0, sio: 1'b0, exp_fmt: 1'b0};
    tbl[1] = '{bank: 2, pat: 1, mode: 1, pad: 1'b0, sio: 1'b0, exp_fmt: 1'b0};
    tbl[2] = '{bank: 1, pat: 2, mode: 0, pad: 1'b1, sio: 1'b0, exp_fmt: 1'b1};
    tbl[3] = '{bank: 0, pat: 2, mode: 2, pad: 1'b0, sio: 1'b1, exp_fmt: 1'b0};

    repeat (3) @(negedge clk);
    srst = 1'b0;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(row_valid), 128'(0));
    check("rst_raddr", 128'({raddr_c2, raddr_c1, raddr_c0}), 128'(0));
    check("rst_flags", 128'({done, cfg_err, fmt_err}), 128'(0));
    check("rst_row", row_data, 128'(0));
    check("rst_idx", 128'(row_idx), 128'(0));
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      load(tbl[r].bank, tbl[r].pat, tbl[r].pad);
      run_readout(tbl[r].bank, tbl[r].pat, tbl[r].mode, tbl[r].sio, tbl[r].exp_fmt, 1'b0, 0);
    end

    // Invalid bank select.
    start = 1'b1;
    bank_sel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    bank_sel = 2'd0;
    check("cfg_err_pulse", 128'(cfg_err), 128'(1));
    check("cfg_busy", 128'(busy), 128'(0));
    check("cfg_raddr", 128'({raddr_c2, raddr_c1, raddr_c0}), 128'(0));
    @(negedge clk);
    check("cfg_err_clear", 128'(cfg_err), 128'(0));
    check("cfg_still_idle", 128'(busy), 128'(0));

    // Start in the done cycle, then reset at READ cycle 8.
    load(2, 0, 1'b0);
    load(1, 1, 1'b0);
    run_readout(2, 0, 0, 1'b0, 1'b0, 1'b1, 1);
    repeat (7) @(negedge clk);
    check("raddr_c1_mid", 128'({raddr_c2, raddr_c1, raddr_c0}), 128'(18'd7 << 6));
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_valid", 128'(row_valid), 128'(0));
    check("mid_rst_raddr", 128'({raddr_c2, raddr_c1, raddr_c0}), 128'(0));
    check("mid_rst_row", row_data, 128'(0));
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("no_done_after_rst", 128'(done_cnt), 128'(0));
    run_readout(1, 1, 1, 1'b0, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
